// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU program-counter stage.
package ppu_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } pc_state_t;

   localparam int unsigned PC_INCR      = 4;
   localparam int unsigned PC_W_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned CNT_W_DEF    = 16;

endpackage

// File: rtl/pc_redirect_stage_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pc_redirect_stage.sv
// PC stage: sequential fetch, load-use stall, EX-stage redirect with flushes,
// and a sticky HALT on a misaligned redirect target.
module pc_redirect_stage
   import ppu_pkg::*;
#(
   parameter int unsigned      PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEF),
   parameter int unsigned      CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             conditionalS,
   input  logic             jump,
   input  logic [PC_W-1:0]  target_addr,
   input  logic             stall,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  npc,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             misalign_fault,
   output logic             halted,
   output logic [CNT_W-1:0] taken_cnt
);

   pc_state_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;

   logic            redirect_req;
   logic            aligned;
   logic            running;
   logic            accept;
   logic            misalign;
   logic [PC_W-1:0] pc_inc;

   always_comb begin
      redirect_req = conditionalS | jump;
      aligned      = (target_addr[1:0] == 2'b00);
      running      = (state_q == RUN);
      accept       = running & redirect_req & aligned;
      misalign     = running & redirect_req & ~aligned;
      pc_inc       = pc_q + PC_W'(PC_INCR);

      // Redirect beats stall; a misaligned target freezes everything.
      pc_d    = pc_q;
      state_d = state_q;
      fault_d = 1'b0;
      if (accept) begin
         pc_d = target_addr;
      end else if (misalign) begin
         state_d = HALT;
         fault_d = 1'b1;
      end else if (running && !stall) begin
         pc_d = pc_inc;
      end

      // Combinational outputs are forced quiet while reset is asserted.
      if_id_flush = ~reset & accept;
      id_ex_flush = ~reset & (accept | (running & ~redirect_req & stall));
      halted      = ~reset & ~running;
      npc         = reset ? '0 : pc_inc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_taken_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (accept),
      .count (taken_cnt)
   );

   assign pc             = pc_q;
   assign misalign_fault = fault_q;

endmodule

// File: tb/tb_pc_redirect_stage.sv
// Directed bench for pc_redirect_stage: vector table plus wrap and saturation sequences.
module tb_pc_redirect_stage;

   logic        clk;
   logic        reset;
   logic        conditionalS;
   logic        jump;
   logic [31:0] target_addr;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        misalign_fault;
   logic        halted;
   logic [15:0] taken_cnt;

   int n_vec = 0;
   int n_mis = 0;

   pc_redirect_stage dut (
      .clk            (clk),
      .reset          (reset),
      .conditionalS   (conditionalS),
      .jump           (jump),
      .target_addr    (target_addr),
      .stall          (stall),
      .pc             (pc),
      .npc            (npc),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .misalign_fault (misalign_fault),
      .halted         (halted),
      .taken_cnt      (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        cs;
      logic        jmp;
      logic [31:0] tgt;
      logic        stl;
      logic [31:0] e_pc;
      logic        e_iif;
      logic        e_iex;
      logic        e_flt;
      logic        e_hlt;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs[NV];

   function automatic vec_t mk(logic rst, logic cs, logic jmp, logic [31:0] tgt, logic stl,
                               logic [31:0] e_pc, logic e_iif, logic e_iex, logic e_flt,
                               logic e_hlt, logic [15:0] e_cnt);
      vec_t v;
      v.rst = rst; v.cs = cs; v.jmp = jmp; v.tgt = tgt; v.stl = stl;
      v.e_pc = e_pc; v.e_iif = e_iif; v.e_iex = e_iex; v.e_flt = e_flt;
      v.e_hlt = e_hlt; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic cs, input logic jmp,
                        input logic [31:0] tgt, input logic stl);
      reset        = rst;
      conditionalS = cs;
      jump         = jmp;
      target_addr  = tgt;
      stall        = stl;
   endtask

   initial begin
      // rst cs jmp tgt stl | pc iif iex flt hlt cnt   (values seen before the edge)
      vecs[0]  = mk(1, 1, 0, 32'h40,  0, 32'h0,   0, 0, 0, 0, 16'd0);
      vecs[1]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 16'd0);
      vecs[2]  = mk(0, 0, 0, 32'h0,   0, 32'h4,   0, 0, 0, 0, 16'd0);
      vecs[3]  = mk(0, 0, 0, 32'h0,   0, 32'h8,   0, 0, 0, 0, 16'd0);
      vecs[4]  = mk(0, 0, 0, 32'h0,   0, 32'hC,   0, 0, 0, 0, 16'd0);
      vecs[5]  = mk(0, 1, 0, 32'h40,  0, 32'h10,  1, 1, 0, 0, 16'd0);
      vecs[6]  = mk(0, 0, 1, 32'h20,  0, 32'h40,  1, 1, 0, 0, 16'd1);
      vecs[7]  = mk(0, 0, 0, 32'h0,   1, 32'h20,  0, 1, 0, 0, 16'd2);
      vecs[8]  = mk(0, 0, 0, 32'h0,   1, 32'h20,  0, 1, 0, 0, 16'd2);
      vecs[9]  = mk(0, 0, 0, 32'h0,   1, 32'h20,  0, 1, 0, 0, 16'd2);
      vecs[10] = mk(0, 0, 0, 32'h0,   0, 32'h20,  0, 0, 0, 0, 16'd2);
      vecs[11] = mk(0, 0, 0, 32'h0,   0, 32'h24,  0, 0, 0, 0, 16'd2);
      vecs[12] = mk(0, 0, 1, 32'h100, 1, 32'h28,  1, 1, 0, 0, 16'd2);
      vecs[13] = mk(0, 1, 0, 32'h200, 0, 32'h100, 1, 1, 0, 0, 16'd3);
      vecs[14] = mk(0, 0, 1, 32'h300, 0, 32'h200, 1, 1, 0, 0, 16'd4);
      vecs[15] = mk(0, 1, 0, 32'h42,  0, 32'h300, 0, 0, 0, 0, 16'd5);
      vecs[16] = mk(0, 0, 1, 32'h400, 0, 32'h300, 0, 0, 1, 1, 16'd5);
      vecs[17] = mk(0, 1, 0, 32'h500, 1, 32'h300, 0, 0, 0, 1, 16'd5);
      vecs[18] = mk(1, 0, 1, 32'h600, 0, 32'h300, 0, 0, 0, 0, 16'd5);
      vecs[19] = mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 16'd0);
      vecs[20] = mk(0, 0, 1, 32'h8,   0, 32'h4,   1, 1, 0, 0, 16'd0);
      vecs[21] = mk(1, 1, 0, 32'h80,  0, 32'h8,   0, 0, 0, 0, 16'd1);
      vecs[22] = mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 16'd0);

      drive(1, 0, 0, 32'h0, 0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         #1;
         drive(vecs[i].rst, vecs[i].cs, vecs[i].jmp, vecs[i].tgt, vecs[i].stl);
         @(negedge clk);
         chk($sformatf("v%0d pc", i),        pc,                      vecs[i].e_pc);
         chk($sformatf("v%0d npc", i),       npc,                     vecs[i].rst ? 32'h0 : vecs[i].e_pc + 32'd4);
         chk($sformatf("v%0d if_id", i),     32'(if_id_flush),        32'(vecs[i].e_iif));
         chk($sformatf("v%0d id_ex", i),     32'(id_ex_flush),        32'(vecs[i].e_iex));
         chk($sformatf("v%0d fault", i),     32'(misalign_fault),     32'(vecs[i].e_flt));
         chk($sformatf("v%0d halted", i),    32'(halted),             32'(vecs[i].e_hlt));
         chk($sformatf("v%0d taken_cnt", i), 32'(taken_cnt),          32'(vecs[i].e_cnt));
         @(posedge clk);
      end

      // PC wraps from the top of the address space with no fault.
      #1;
      drive(0, 0, 1, 32'hFFFF_FFFC, 0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 32'h0, 0);
      @(negedge clk);
      chk("wrap pc_top", pc, 32'hFFFF_FFFC);
      chk("wrap npc", npc, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("wrap pc", pc, 32'h0);
      chk("wrap fault", 32'(misalign_fault), 32'h0);
      chk("wrap halted", 32'(halted), 32'h0);

      // Saturation: 2^16+1 accepted redirects from a fresh reset.
      @(posedge clk);
      #1;
      drive(1, 0, 0, 32'h0, 0);
      @(posedge clk);
      #1;
      drive(0, 0, 1, 32'h10, 0);
      repeat (65535) @(posedge clk);
      @(negedge clk);
      chk("sat cnt_at_max", 32'(taken_cnt), 32'h0000_FFFF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("sat cnt_held", 32'(taken_cnt), 32'h0000_FFFF);
      chk("sat pc", pc, 32'h10);
      #1;
      drive(0, 0, 0, 32'h0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
